// File: rtl/axis_sa_pkg.sv
// Shared types and default geometry for the axis_sa pipeline.
//   SA_R, SA_C, SA_WY : matrix geometry and word width used by axis_sa.
//   SA_WO, SA_SHIFT   : requantised output width and rounding shift.
//   y_word_t          : one signed accumulator word from axis_sa.
//   q_word_t          : one signed requantised word.
//   bank_state_t      : occupancy of one ping-pong bank.
package axis_sa_pkg;

  localparam int SA_R     = 8;
  localparam int SA_C     = 4;
  localparam int SA_WY    = 15;
  localparam int SA_WO    = 8;
  localparam int SA_SHIFT = 2;

  typedef logic signed [SA_WY-1:0] y_word_t;
  typedef logic signed [SA_WO-1:0] q_word_t;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL
  } bank_state_t;

endpackage

// File: rtl/sa_requant.sv
// Combinational requantiser for one word: round half up, arithmetic shift
// right by SHIFT, then saturate into the signed WO-bit range.
//   x : signed WY-bit input word
//   q : signed WO-bit requantised word
module sa_requant #(
  parameter int WY    = 15,
  parameter int WO    = 8,
  parameter int SHIFT = 2
) (
  input  logic signed [WY-1:0] x,
  output logic signed [WO-1:0] q
);

  // (2**SHIFT)/2 is the half-LSB rounding term and is 0 when SHIFT is 0.
  localparam logic signed [WY:0] RND  = (WY+1)'((2**SHIFT) / 2);
  localparam logic signed [WY:0] QMAX = (WY+1)'((2**(WO-1)) - 1);
  localparam logic signed [WY:0] QMIN = ~QMAX;

  logic signed [WY:0] t;
  logic signed [WY:0] sh;

  always_comb begin
    // One guard bit keeps x + RND from overflowing.
    t  = $signed({x[WY-1], x}) + RND;
    sh = t >>> SHIFT;
    if (sh > QMAX) begin
      q = QMAX[WO-1:0];
    end else if (sh < QMIN) begin
      q = QMIN[WO-1:0];
    end else begin
      q = sh[WO-1:0];
    end
  end

endmodule

// File: rtl/axis_y_transpose.sv
// Requantise-and-transpose stage behind axis_sa. Accepts C column beats of R
// words per matrix, stores requantised words in a ping-pong buffer, and emits
// R row beats of C words. One bank fills while the other drains.
//   clk, rstn        : clock, asynchronous active-low reset
//   s_valid/s_ready  : input handshake
//   s_data           : one column of Y, word r = Y[r][col]
//   s_last           : final column of a matrix
//   m_valid/m_ready  : output handshake
//   m_data           : one row of Yq, word c = Yq[row][c]
//   m_last           : high on output row R-1
//   err              : sticky framing error (early or missing s_last)
module axis_y_transpose
  import axis_sa_pkg::*;
#(
  parameter int R     = SA_R,
  parameter int C     = SA_C,
  parameter int WY    = SA_WY,
  parameter int WO    = SA_WO,
  parameter int SHIFT = SA_SHIFT
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [R-1:0][WY-1:0]   s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [C-1:0][WO-1:0]   m_data,
  output logic                   m_last,
  output logic                   err
);

  localparam int CW = (C > 1) ? $clog2(C) : 1;
  localparam int RW = (R > 1) ? $clog2(R) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(C - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(R - 1);

  bank_state_t state_q [2];
  bank_state_t state_d [2];

  logic          wr_bank;
  logic          rd_bank;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;

  logic [WO-1:0] mem [2][C][R];
  logic [R-1:0][WO-1:0] q_col;

  logic accept;
  logic col_end;
  logic close;
  logic m_fire;
  logic drain;

  for (genvar r = 0; r < R; r++) begin : g_rq
    sa_requant #(
      .WY   (WY),
      .WO   (WO),
      .SHIFT(SHIFT)
    ) u_rq (
      .x(s_data[r]),
      .q(q_col[r])
    );
  end

  assign s_ready = (state_q[wr_bank] != FULL);
  assign accept  = s_valid & s_ready;
  assign col_end = (col_cnt == COL_LAST);
  assign close   = accept & (s_last | col_end);

  assign m_valid = (state_q[rd_bank] == FULL);
  assign m_fire  = m_valid & m_ready;
  assign drain   = m_fire & (row_cnt == ROW_LAST);
  assign m_last  = m_valid & (row_cnt == ROW_LAST);

  always_comb begin
    m_data = '0;
    for (int unsigned c = 0; c < C; c++) begin
      m_data[c] = mem[rd_bank][c][row_cnt];
    end
  end

  // Bank occupancy. wr_bank and rd_bank never address the same bank in a
  // cycle where both a close and a drain happen, so the two updates are
  // independent.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d[wr_bank] = close ? FULL : FILLING;
    end
    if (drain) begin
      state_d[rd_bank] = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned b = 0; b < 2; b++) begin
        state_q[b] <= EMPTY;
      end
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned c = 0; c < C; c++) begin
          for (int unsigned r = 0; r < R; r++) begin
            mem[b][c][r] <= '0;
          end
        end
      end
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      col_cnt <= '0;
      row_cnt <= '0;
      err     <= 1'b0;
    end else begin
      if (accept) begin
        for (int unsigned r = 0; r < R; r++) begin
          mem[wr_bank][col_cnt][r] <= q_col[r];
        end
        if (close) begin
          // Early s_last: clear the columns this matrix never wrote so stale
          // data from an older matrix in this bank cannot leak out.
          if (!col_end) begin
            for (int unsigned j = 0; j < C; j++) begin
              if (CW'(j) > col_cnt) begin
                for (int unsigned r = 0; r < R; r++) begin
                  mem[wr_bank][j][r] <= '0;
                end
              end
            end
          end
          // Framing is good only when s_last coincides with the last column.
          if (s_last != col_end) begin
            err <= 1'b1;
          end
          col_cnt <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end

      if (m_fire) begin
        if (row_cnt == ROW_LAST) begin
          row_cnt <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          row_cnt <= row_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_y_transpose.sv
module tb_axis_y_transpose;
  import axis_sa_pkg::*;

  localparam int R     = 8;
  localparam int C     = 4;
  localparam int WY    = 15;
  localparam int WO    = 8;
  localparam int SHIFT = 2;
  localparam int LIMIT = 5000;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 s_valid;
  logic                 s_ready;
  logic [R-1:0][WY-1:0] s_data;
  logic                 s_last;
  logic                 m_valid;
  logic                 m_ready;
  logic [C-1:0][WO-1:0] m_data;
  logic                 m_last;
  logic                 err;

  logic m_ready_fix;
  logic rnd_ready = 1'b0;
  bit   rand_mode;

  assign m_ready = rand_mode ? rnd_ready : m_ready_fix;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_ready = 1'($urandom_range(0, 1));
  end

  axis_y_transpose #(
    .R    (R),
    .C    (C),
    .WY   (WY),
    .WO   (WO),
    .SHIFT(SHIFT)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .s_last (s_last),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .m_last (m_last),
    .err    (err)
  );

  typedef struct {
    logic [C-1:0][WO-1:0] data;
    logic                 last;
  } beat_t;

  beat_t exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    out_cnt     = 0;
  int    mat [R][C];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference requantiser: floor((x + half) / 2^SHIFT), then clamp.
  function automatic int rq(input int x);
    int t, d, q;
    d = 2 ** SHIFT;
    t = x + d / 2;
    q = (t >= 0) ? t / d : -((-t + d - 1) / d);
    if (q > 2 ** (WO - 1) - 1) q = 2 ** (WO - 1) - 1;
    if (q < -(2 ** (WO - 1))) q = -(2 ** (WO - 1));
    return q;
  endfunction

  // Output monitor: every row handshake is checked against the expected queue.
  always @(negedge clk) begin
    beat_t e;
    if (rstn && m_valid && m_ready) begin
      out_cnt++;
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_beat observed=%0h expected=none", m_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("m_data", 64'(m_data), 64'(e.data));
        check("m_last", 64'(m_last), 64'(e.last));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Expected rows for the current mat when only the first ncols columns arrive.
  task automatic push_matrix(input int ncols);
    beat_t b;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        b.data[c] = (c < ncols) ? WO'(rq(mat[r][c])) : '0;
      end
      b.last = (r == R - 1);
      exp_q.push_back(b);
    end
  endtask

  // Presents one beat and returns #1 after the posedge it was accepted on;
  // s_valid is left high so back-to-back beats have no bubble.
  task automatic send_col(input int j, input bit last);
    int n = 0;
    s_valid = 1'b1;
    s_last  = last;
    for (int r = 0; r < R; r++) s_data[r] = WY'(mat[r][j]);
    @(negedge clk);
    while (!s_ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("s_accept_in_time", 64'(n < LIMIT), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_matrix(input int ncols, input bit with_last);
    push_matrix(ncols);
    for (int j = 0; j < ncols; j++) send_col(j, with_last && (j == ncols - 1));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rstn = 1'b0;
    #3;
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_pattern();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) mat[r][c] = 16 * r + 4 * c;
  endtask

  task automatic fill_random();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        if ($urandom_range(0, 1) == 1) mat[r][c] = int'($urandom_range(0, 1200)) - 600;
        else mat[r][c] = int'($urandom_range(0, 2 ** WY - 1)) - 2 ** (WY - 1);
  endtask

  int base;
  int edges [R] = '{1000, -1000, 6, -6, 1, 2, -2, 0};

  initial begin
    rstn        = 1'b0;
    s_valid     = 1'b0;
    s_data      = '0;
    s_last      = 1'b0;
    m_ready_fix = 1'b1;
    rand_mode   = 1'b0;
    #12;
    check("rst_s_ready", 64'(s_ready), 64'd1);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_last",  64'(m_last),  64'd0);
    check("rst_m_data",  64'(m_data),  64'd0);
    check("rst_err",     64'(err),     64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // 1: single matrix, valid exactly one cycle after the closing beat.
    fill_pattern();
    push_matrix(C);
    for (int j = 0; j < C; j++) begin
      send_col(j, j == C - 1);
      check("t1_m_valid_timing", 64'(m_valid), 64'(j == C - 1));
    end
    idle();
    wait_drain();
    check("t1_err", 64'(err), 64'd0);

    // 2: requantisation edge values in column 0.
    fill_pattern();
    for (int r = 0; r < R; r++) mat[r][0] = edges[r];
    send_matrix(C, 1'b1);
    idle();
    wait_drain();

    // 3: back-pressure with three matrices.
    m_ready_fix = 1'b0;
    base = out_cnt;
    fill_random();
    send_matrix(C, 1'b1);
    fill_random();
    send_matrix(C, 1'b1);
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("t3_both_full_s_ready", 64'(s_ready), 64'd0);
    check("t3_m_valid", 64'(m_valid), 64'd1);
    fill_random();
    push_matrix(C);
    m_ready_fix = 1'b1;
    send_col(0, 1'b0);
    check("t3_third_after_drain", 64'((out_cnt - base) >= R), 64'd1);
    for (int j = 1; j < C; j++) send_col(j, j == C - 1);
    idle();
    wait_drain();
    check("t3_row_count", 64'(out_cnt - base), 64'(3 * R));
    check("t3_err", 64'(err), 64'd0);

    // 4a: early s_last on beat 1, then a normal matrix.
    fill_random();
    send_matrix(2, 1'b1);
    idle();
    check("t4_early_last_err", 64'(err), 64'd1);
    fill_random();
    send_matrix(C, 1'b1);
    idle();
    wait_drain();

    // 4b: missing s_last after a reset.
    pulse_reset();
    check("t4_err_cleared", 64'(err), 64'd0);
    fill_random();
    send_matrix(C, 1'b0);
    idle();
    check("t4_missing_last_err", 64'(err), 64'd1);
    wait_drain();

    // 5: asynchronous reset during output row 3.
    base = out_cnt;
    fill_pattern();
    send_matrix(C, 1'b1);
    idle();
    begin
      int n = 0;
      while ((out_cnt - base) < 3 && n < LIMIT) begin
        @(posedge clk);
        n++;
      end
      check("t5_reach_row3", 64'((out_cnt - base) >= 3), 64'd1);
    end
    @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    check("t5_m_valid", 64'(m_valid), 64'd0);
    check("t5_m_last",  64'(m_last),  64'd0);
    check("t5_s_ready", 64'(s_ready), 64'd1);
    check("t5_err",     64'(err),     64'd0);
    check("t5_m_data",  64'(m_data),  64'd0);
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    fill_pattern();
    send_matrix(C, 1'b1);
    idle();
    wait_drain();

    // 6: soak, continuous upstream, random downstream ready.
    rand_mode = 1'b1;
    base = out_cnt;
    for (int k = 0; k < 50; k++) begin
      fill_random();
      send_matrix(C, 1'b1);
    end
    idle();
    wait_drain();
    check("t6_row_count", 64'(out_cnt - base), 64'(50 * R));
    check("t6_err", 64'(err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_y_transpose.md
Name: axis_y_transpose

Overview:
- Downstream stage of axis_sa. Consumes its output stream: C beats per matrix, each beat one column of Y (R words of WY bits), s_last on the final column.
- Requantises every element to WO bits and transposes the matrix. Emits R beats per matrix, each beat one row of Y (C words of WO bits).
- Ping-pong double buffer: one matrix can be filled while the previous one drains.

Parameters:
- R, 8, rows of Y; words per input beat; output beats per matrix.
- C, 4, columns of Y; input beats per matrix; words per output beat.
- WY, 15, input word width, signed.
- WO, 8, output word width, signed; WO <= WY.
- SHIFT, 2, arithmetic right shift applied before saturation; 0 <= SHIFT < WY.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid & s_ready.
- s_data  in  R*WY  packed [R-1:0][WY-1:0]; word r is Y[r][col].
- s_last  in  1  final column of a matrix.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  C*WO  packed [C-1:0][WO-1:0]; word c is Yq[row][c].
- m_last  out  1  high on output row R-1.
- err  out  1  sticky framing error.

Behaviour:
- Reset (async, rstn=0): both banks EMPTY and zeroed; wr_bank=rd_bank=0; col_cnt=row_cnt=0; s_ready=1, m_valid=0, m_last=0, m_data=0, err=0.
- Bank state per bank: EMPTY -> FILLING on the first accepted beat -> FULL when the matrix closes -> EMPTY when its row R-1 handshakes out.
- Write side:
  - s_ready = (state[wr_bank] != FULL).
  - On an accepted beat: bank[wr_bank][col_cnt][r] <= requant(s_data[r]) for all r; col_cnt increments.
- Matrix close: the matrix closes on the accepted beat with s_last=1, or with col_cnt=C-1, whichever comes first.
  - On close: state FULL, col_cnt <= 0, wr_bank toggles.
  - Early s_last (col_cnt<C-1): the unwritten columns of that bank are forced to 0 and err <= 1.
  - Beat col_cnt=C-1 without s_last: the matrix closes anyway and err <= 1.
- Read side:
  - m_valid = (state[rd_bank]==FULL).
  - m_data[c] = bank[rd_bank][c][row_cnt].
  - m_last = m_valid & (row_cnt==R-1).
  - On handshake row_cnt increments. At R-1: row_cnt <= 0, bank EMPTY, rd_bank toggles.
- Latency: the first output beat is valid the cycle after the closing input beat is accepted. No combinational path from s_* to m_*.
- Simultaneous close on one bank and final drain of the other in the same cycle: both updates apply. Throughput stays C in / R out with no bubble.
- Both banks FULL: s_ready=0 until a drain completes. s_ready rises the cycle after that drain completes.
- m_data and m_last are held stable while m_valid & !m_ready (AXIS rule).
- requant(x):
  - Compute t = x + (SHIFT>0 ? 2^(SHIFT-1) : 0) in WY+1 bits.
  - Arithmetic shift right by SHIFT (round half up).
  - Saturate to [-2^(WO-1), 2^(WO-1)-1].
- err clears only on reset.
- Reset mid-operation: all in-flight data is discarded and every output returns to its reset value immediately.

Decomposition:
- Package axis_sa_pkg holds:
  - typedef y_word_t (logic signed [WY-1:0]);
  - typedef q_word_t (logic signed [WO-1:0]);
  - enum bank_state_t {EMPTY, FILLING, FULL}.
- Package parameters are set from the same R, C, WY values as axis_sa.
- One sub-module: sa_requant, combinational shift-round-saturate for one word, instantiated R times on the write path.

Test Plan:
1. Single matrix; R=8, C=4, SHIFT=2, WO=8; input Y[r][j]=16r+4j, last on beat 3, m_ready=1 -> 8 output beats, beat r = {4r, 4r+1, 4r+2, 4r+3}; m_last only on beat 7; first m_valid 1 cycle after the last input handshake; err=0.
2. Requant edges in one column: inputs 1000, -1000, 6, -6, 1, 2, -2, 0 -> outputs 127, -128, 2, -1, 0, 1, 0, 0.
3. Back-pressure: m_ready=0, push 3 matrices -> 8 beats accepted, then s_ready=0. Raise m_ready -> the third matrix is accepted only after matrix 0 drains; output order is 0, 1, 2 and bit-exact.
4. Framing:
   - s_last on beat 1 -> err=1; columns 2-3 output as 0; 8 rows emitted; the next matrix starts at col 0.
   - Separately, 4 beats without s_last -> the matrix closes normally and err=1.
5. Reset mid-drain: assert rstn=0 during output row 3 -> m_valid=0, m_last=0, s_ready=1, err=0 asynchronously. After release a fresh matrix from scenario 1 outputs correctly.
6. Soak: 50 random matrices, P_VALID=1 upstream, P_READY=50% downstream, chained behind axis_sa -> all outputs match the reference model of requant(X·K) transposed.
